// File: rtl/dendy_pkg.sv
// Shared definitions for the Dendy bus blocks.
//   dma_state_t  : sprite DMA engine state encoding
//   ADDR_OAMDMA  : CPU register that starts a sprite DMA ($4014)
//   ADDR_OAMDATA : PPU OAM data port that receives the copied bytes ($2004)
package dendy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// oam_dma - sprite DMA engine sitting between the CPU and the memory/PPU bus.
//
// While idle the CPU bus (cpu_a/cpu_d/cpu_r/cpu_w) is passed straight through
// and cpu_ce follows ce. A CPU write to $4014 latches the source page; the
// engine then stalls the CPU (cpu_ce=0) and copies $XX00-$XXFF to $2004 with
// alternating read/write ticks, then hands the bus back.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   ce             CPU-rate tick; all state advances only when high
//   cpu_a/d/r/w    CPU-side address, write data, read and write strobes
//   cpu_ce         gated clock-enable returned to the CPU
//   A, D, R, W     bus address, write data, read and write strobes
//   I              bus read data, valid in the same tick as R
//   state_dbg      current FSM state (dma_state_t encoding) for observation
//
// Configuration macro: OAM_DMA_ALIGN_EN
//   defined   : an extra ALIGN tick is inserted when the HALT tick falls on
//               odd CPU-cycle parity (513 or 514 stall ticks)
//   undefined : HALT always goes straight to READ (fixed 513 stall ticks) and
//               the parity register is not built
//
// Handshake: there is no valid/ready pair; every transfer step is qualified
// solely by ce, and read data on I is consumed in the same ce tick as R=1.
module oam_dma
    import dendy_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic        cpu_ce,
    output logic [15:0] A,
    input  logic [7:0]  I,
    output logic [7:0]  D,
    output logic        R,
    output logic        W,
    output logic [2:0]  state_dbg
);

    dma_state_t state;
    dma_state_t state_next;

    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       dma_start;

    // The $4014 write is recognised only on a real CPU tick.
    assign dma_start = ce && cpu_w && (cpu_a == ADDR_OAMDMA);

    assign state_dbg = state;

`ifdef OAM_DMA_ALIGN_EN
    // CPU-cycle parity, free-running on every ce tick.
    logic odd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            odd <= 1'b0;
        end else if (ce) begin
            odd <= ~odd;
        end
    end
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // Next-state logic (evaluated per tick; the register applies ce)
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (dma_start) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_next = odd ? ST_ALIGN : ST_READ;
`else
                state_next = ST_READ;
`endif
            end
            ST_ALIGN: state_next = ST_READ;
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: begin
                // idx still holds the byte just written; $FF is the last one.
                state_next = (idx == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Transfer datapath: page/index/data registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            page <= 8'h00;
            idx  <= 8'h00;
            data <= 8'h00;
        end else if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (dma_start) begin
                        page <= cpu_d;
                        idx  <= 8'h00;
                    end
                end
                ST_READ:  data <= I;
                // 8-bit wrap: never carries into page.
                ST_WRITE: idx <= idx + 8'd1;
                default:  ;
            endcase
        end
    end

    // Output logic: passthrough in IDLE, engine-owned bus otherwise
    always_comb begin
        A      = {page, idx};
        D      = data;
        R      = 1'b0;
        W      = 1'b0;
        cpu_ce = 1'b0;
        case (state)
            ST_IDLE: begin
                A      = cpu_a;
                D      = cpu_d;
                R      = cpu_r;
                W      = cpu_w;
                cpu_ce = ce;
            end
            ST_READ: begin
                R = 1'b1;
            end
            ST_WRITE: begin
                A = ADDR_OAMDATA;
                W = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: table-driven passthrough vectors plus hand-written
// DMA transfer sequences (parity, page $FF, ce hold, reset abort).
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce    = 1'b1;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_d = 8'h00;
    logic        cpu_r = 1'b0;
    logic        cpu_w = 1'b0;
    logic        cpu_ce;
    logic [15:0] A;
    logic [7:0]  I;
    logic [7:0]  D;
    logic        R;
    logic        W;
    logic [2:0]  state_dbg;

    localparam logic [2:0] S_IDLE = 3'd0;

    int n_checks = 0;
    int n_fail   = 0;
    logic odd_m  = 1'b0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #20 clock = ~clock;

    oam_dma dut (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_r     (cpu_r),
        .cpu_w     (cpu_w),
        .cpu_ce    (cpu_ce),
        .A         (A),
        .I         (I),
        .D         (D),
        .R         (R),
        .W         (W),
        .state_dbg (state_dbg)
    );

    // Memory model: page $02 holds n^$5A; other pages a distinct pattern so
    // a wrap from $FFxx into $00xx would show up as wrong data.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always_comb begin
        I = 8'h00;
        if (R) I = mem_byte(A);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Finish the current tick: clock edge, then model parity update.
    task automatic finish_tick();
        @(posedge clock);
        #1;
        if (ce) odd_m = ~odd_m;
    endtask

    task automatic idle_step();
        ce = 1'b1; cpu_a = 16'h0000; cpu_d = 8'h00; cpu_r = 1'b0; cpu_w = 1'b0;
        @(negedge clock);
        finish_tick();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        ce;
        logic [15:0] a;
        logic [7:0]  d;
        logic        r;
        logic        w;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic        exp_r;
        logic        exp_w;
        logic        exp_cpu_ce;
    } vec_t;

    vec_t vecs[8];

    // ---------------- DMA sequence driver ----------------
    task automatic run_dma(input logic [7:0] pg, input bit want_align,
                           input int hold_at, input int abort_at);
        bit   align_exp;
        bit   held;
        int   stall, reads, writes, first_read, t;
        logic [2:0]  s0;
        logic [15:0] a0;
        logic [7:0]  wexp;

`ifdef OAM_DMA_ALIGN_EN
        // ALIGN happens when parity at the HALT tick is odd, i.e. parity at
        // the trigger tick is even.
        if ((odd_m == 1'b0) != want_align) idle_step();
        align_exp = want_align;
`else
        if (want_align) idle_step();
        align_exp = 1'b0;
`endif
        exp_q.delete();
        for (int n = 0; n < 256; n++) exp_q.push_back(mem_byte({pg, n[7:0]}));

        // Trigger tick T: the $4014 write itself is still forwarded.
        ce = 1'b1; cpu_a = 16'h4014; cpu_d = pg; cpu_r = 1'b0; cpu_w = 1'b1;
        @(negedge clock);
        chk("trig_A", A, 16'h4014);
        chk("trig_D", D, pg);
        chk("trig_W", W, 1'b1);
        chk("trig_cpu_ce", cpu_ce, 1'b1);
        finish_tick();

        // CPU keeps driving a junk write; it must not reach the bus.
        cpu_a = 16'h1234; cpu_d = 8'hEE; cpu_w = 1'b1;
        stall = 0; reads = 0; writes = 0; first_read = -1; t = 1; held = 0;
        while (t < 1000) begin
            if (!held && hold_at >= 0 && reads == hold_at) begin
                held = 1;
                ce = 1'b0;
                @(negedge clock);
                s0 = state_dbg; a0 = A;
                chk("hold_cpu_ce", cpu_ce, 1'b0);
                for (int k = 0; k < 6; k++) @(posedge clock);
                @(negedge clock);
                chk("hold_state", state_dbg, s0);
                chk("hold_A", A, a0);
                @(posedge clock);
                #1;
                ce = 1'b1;
            end
            @(negedge clock);
            if (abort_at >= 0 && W && writes == abort_at) begin
                cpu_w = 1'b0;
                reset = 1'b1;
                #1;
                chk("abort_state", state_dbg, S_IDLE);
                chk("abort_W", W, 1'b0);
                chk("abort_A", A, 16'h1234);
                chk("abort_cpu_ce", cpu_ce, ce);
                @(posedge clock);
                #1;
                reset = 1'b0;
                odd_m = 1'b0;
                return;
            end
            if (cpu_ce) break;
            stall++;
            if (R) begin
                if (first_read < 0) first_read = t;
                chk("rd_addr", A, {pg, reads[7:0]});
                reads++;
            end
            if (W) begin
                chk("wr_addr", A, 16'h2004);
                wexp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("wr_data", D, wexp);
                writes++;
            end
            if (!R && !W) chk("idle_pos_ok", (t <= (align_exp ? 2 : 1)), 1'b1);
            finish_tick();
            t++;
        end
        chk("no_timeout", (t < 1000), 1'b1);
        chk("stall_ticks", stall, align_exp ? 514 : 513);
        chk("first_read", first_read, align_exp ? 3 : 2);
        chk("write_count", writes, 256);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("idle_next", t, stall + 1);
        chk("end_state", state_dbg, S_IDLE);
        chk("end_pass_A", A, 16'h1234);
        chk("end_pass_W", W, 1'b1);
        cpu_w = 1'b0;
        finish_tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //                 ce  a         d      r  w   A         D      R  W  cpu_ce
        vecs[0] = '{1'b1, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h00, 1, 0, 1'b1};
        vecs[1] = '{1'b1, 16'h1234, 8'hA5, 0, 1, 16'h1234, 8'hA5, 0, 1, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h00, 1, 0, 1'b0};
        vecs[3] = '{1'b0, 16'h4014, 8'h33, 0, 1, 16'h4014, 8'h33, 0, 1, 1'b0};
        vecs[4] = '{1'b1, 16'h2004, 8'hC7, 0, 1, 16'h2004, 8'hC7, 0, 1, 1'b1};
        vecs[5] = '{1'b1, 16'h4015, 8'h12, 0, 1, 16'h4015, 8'h12, 0, 1, 1'b1};
        vecs[6] = '{1'b1, 16'h4014, 8'h00, 1, 0, 16'h4014, 8'h00, 1, 0, 1'b1};
        vecs[7] = '{1'b1, 16'hFFFF, 8'hFF, 0, 0, 16'hFFFF, 8'hFF, 0, 0, 1'b1};

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_state", state_dbg, S_IDLE);
        chk("rst_cpu_ce", cpu_ce, 1'b1);
        chk("rst_A", A, 16'h0000);
        chk("rst_R", R, 1'b0);
        chk("rst_W", W, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        odd_m = 1'b0;

        // Passthrough vectors; none of them may start a DMA.
        for (int i = 0; i < 8; i++) begin
            ce = vecs[i].ce; cpu_a = vecs[i].a; cpu_d = vecs[i].d;
            cpu_r = vecs[i].r; cpu_w = vecs[i].w;
            @(negedge clock);
            chk("vec_A", A, vecs[i].exp_a);
            chk("vec_D", D, vecs[i].exp_d);
            chk("vec_R", R, vecs[i].exp_r);
            chk("vec_W", W, vecs[i].exp_w);
            chk("vec_cpu_ce", cpu_ce, vecs[i].exp_cpu_ce);
            chk("vec_state", state_dbg, S_IDLE);
            finish_tick();
        end
        idle_step();
        @(negedge clock);
        chk("vec_no_start", state_dbg, S_IDLE);
        finish_tick();

        run_dma(8'h02, 1'b0, -1, -1);   // even alignment
        run_dma(8'h02, 1'b1, -1, -1);   // odd alignment
        run_dma(8'hFF, 1'b0, -1, -1);   // page $FF, no wrap
        run_dma(8'h02, 1'b0, 50, -1);   // ce held low mid-transfer
        run_dma(8'h02, 1'b1, -1, 100);  // reset at byte 100
        idle_step();
        run_dma(8'h02, 1'b0, -1, -1);   // clean restart after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #10ms;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
